// File: rtl/bin_frame_scheduler_if.sv
// Amplitude stream into the bin frame scheduler: one bin per beat, bin 0 first,
// in_last marking the final bin of a set.
interface bin_frame_scheduler_if #(
    parameter int AMP_W = 12
);
    logic             in_valid;
    logic             in_ready;
    logic [AMP_W-1:0] in_bin;
    logic             in_last;

    modport master (output in_valid, in_bin, in_last, input in_ready);
    modport slave  (input in_valid, in_bin, in_last, output in_ready);
endinterface

// File: rtl/bin_frame_scheduler.sv
// Collects a set of bin amplitudes into a shadow buffer and commits it to the
// display array during vertical blank, with per-frame peak-hold decay.
module bin_frame_scheduler #(
    parameter int NUM_BINS    = 16,
    parameter int AMP_W       = 12,
    parameter int DECAY       = 16,
    parameter int VBLANK_LINE = 480
) (
    input  logic                    clk_25MHz,
    input  logic                    rst,
    bin_frame_scheduler_if.slave    in_if,
    input  logic [9:0]              hc_out,
    input  logic [9:0]              vc_out,
    output logic [AMP_W-1:0]        disp_bins [NUM_BINS],
    output logic                    commit_done,
    output logic                    framing_err,
    output logic [7:0]              commit_count
);

    localparam int               IDX_W    = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BINS - 1);
    localparam logic [AMP_W-1:0] DEC_AMP  = AMP_W'(DECAY);
    localparam logic [9:0]       VBL_LINE = 10'(VBLANK_LINE);

    typedef enum logic [1:0] {IDLE, FILL, PENDING, COMMIT} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [IDX_W-1:0] cidx;
    logic             vblank_start;
    logic             accept;
    logic             ferr_nxt;
    logic             done_nxt;
    logic [AMP_W-1:0] shadow [NUM_BINS];

    function automatic logic [AMP_W-1:0] decay_sat(input logic [AMP_W-1:0] a);
        if (a > DEC_AMP)
            return a - DEC_AMP;
        return '0;
    endfunction

    function automatic logic [AMP_W-1:0] amp_max(input logic [AMP_W-1:0] a,
                                                 input logic [AMP_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    assign in_if.in_ready = (state == IDLE) || (state == FILL);
    assign accept         = in_if.in_valid && in_if.in_ready;

    // Stage p0: registered start-of-vblank pulse
    always_ff @(posedge clk_25MHz) begin
        if (rst)
            vblank_start <= 1'b0;
        else
            vblank_start <= (hc_out == 10'd0) && (vc_out == VBL_LINE);
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        ferr_nxt  = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE, FILL: begin
                if (accept) begin
                    if (idx == LAST_IDX) begin
                        // A full set is kept even when in_last is missing
                        state_nxt = PENDING;
                        idx_nxt   = '0;
                        ferr_nxt  = !in_if.in_last;
                    end else if (in_if.in_last) begin
                        state_nxt = IDLE;
                        idx_nxt   = '0;
                        ferr_nxt  = 1'b1;
                    end else begin
                        state_nxt = FILL;
                        idx_nxt   = idx + 1'b1;
                    end
                end
            end
            PENDING: begin
                if (vblank_start)
                    state_nxt = COMMIT;
            end
            COMMIT: begin
                if (cidx == LAST_IDX) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            cidx         <= '0;
            commit_done  <= 1'b0;
            framing_err  <= 1'b0;
            commit_count <= 8'd0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            cidx        <= ((state == COMMIT) && (cidx != LAST_IDX)) ? cidx + 1'b1 : '0;
            commit_done <= done_nxt;
            framing_err <= ferr_nxt;
            if (done_nxt)
                commit_count <= commit_count + 8'd1;
        end
    end

    // Shadow is only written while in_ready is high, so it is frozen once a set is pending
    always_ff @(posedge clk_25MHz) begin
        if (accept)
            shadow[idx] <= in_if.in_bin;
    end

    // Stage p1: one display bin per COMMIT cycle, peak-hold with saturating decay
    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            for (int i = 0; i < NUM_BINS; i++)
                disp_bins[i] <= '0;
        end else if (state == COMMIT) begin
            disp_bins[cidx] <= amp_max(shadow[cidx], decay_sat(disp_bins[cidx]));
        end
    end

endmodule

// File: tb/tb_bin_frame_scheduler.sv
// Randomized bench for bin_frame_scheduler against a set-level reference model.
module tb_bin_frame_scheduler;

    localparam int NB  = 16;
    localparam int AW  = 12;
    localparam int DEC = 16;
    localparam int VBL = 480;

    logic          clk_25MHz = 1'b0;
    logic          rst;
    logic [9:0]    hc_out;
    logic [9:0]    vc_out;
    logic [AW-1:0] disp_bins [NB];
    logic          commit_done;
    logic          framing_err;
    logic [7:0]    commit_count;

    bin_frame_scheduler_if #(.AMP_W(AW)) bus();

    bin_frame_scheduler #(
        .NUM_BINS(NB), .AMP_W(AW), .DECAY(DEC), .VBLANK_LINE(VBL)
    ) dut (
        .clk_25MHz   (clk_25MHz),
        .rst         (rst),
        .in_if       (bus),
        .hc_out      (hc_out),
        .vc_out      (vc_out),
        .disp_bins   (disp_bins),
        .commit_done (commit_done),
        .framing_err (framing_err),
        .commit_count(commit_count)
    );

    always #20 clk_25MHz = ~clk_25MHz;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: display array, set being filled, pending set, frame count
    int m_disp [NB];
    int m_cur  [NB];
    int m_pend [NB];
    bit m_pending;
    int m_cnt;
    int m_count;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d (0x%0h) expected %0d", tag, obs, obs, exp);
    endtask

    function automatic int rand_amp();
        case ($urandom_range(0, 3))
            0:       return 0;
            1:       return (1 << AW) - 1;
            default: return int'($urandom_range(0, (1 << AW) - 1));
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NB; k++) begin
            m_disp[k] = 0;
            m_cur[k]  = 0;
            m_pend[k] = 0;
        end
        m_pending = 0;
        m_cnt     = 0;
        m_count   = 0;
    endtask

    task automatic model_beat(input int v, input bit last, output bit err);
        m_cur[m_cnt] = v;
        err = 0;
        if (m_cnt == NB - 1) begin
            m_pend    = m_cur;
            m_pending = 1;
            err       = !last;
            m_cnt     = 0;
        end else if (last) begin
            err   = 1;
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
    endtask

    function automatic int commit_value(input int old_v, input int new_v);
        int dec;
        dec = (old_v > DEC) ? old_v - DEC : 0;
        return (new_v > dec) ? new_v : dec;
    endfunction

    task automatic model_commit();
        for (int k = 0; k < NB; k++)
            m_disp[k] = commit_value(m_disp[k], m_pend[k]);
        m_count   = (m_count + 1) % 256;
        m_pending = 0;
    endtask

    task automatic check_disp(input string tag);
        for (int k = 0; k < NB; k++)
            chk($sformatf("%s[%0d]", tag, k), 32'(disp_bins[k]), 32'(m_disp[k]));
        chk({tag, "_count"}, 32'(commit_count), 32'(m_count));
    endtask

    task automatic wander_counters();
        hc_out = 10'($urandom_range(1, 799));
        vc_out = 10'($urandom_range(0, 524));
        if ($urandom_range(0, 7) == 0) begin
            hc_out = 10'd0;
            vc_out = ($urandom_range(0, 1) != 0) ? 10'(VBL - 1) : 10'(VBL + 1);
        end
    endtask

    task automatic drive_beat(input int v, input bit last);
        bit err;
        repeat ($urandom_range(0, 2)) begin
            bus.in_valid = 1'b0;
            wander_counters();
            @(posedge clk_25MHz); #1;
        end
        wander_counters();
        bus.in_valid = 1'b1;
        bus.in_bin   = AW'(v);
        bus.in_last  = last;
        chk("in_ready_beat", 32'(bus.in_ready), 32'd1);
        @(posedge clk_25MHz); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        model_beat(v, last, err);
        chk("framing_err", 32'(framing_err), 32'(err));
    endtask

    task automatic send_beats(input int n, input int fixed, input bit last_on_final);
        for (int b = 0; b < n; b++)
            drive_beat((fixed >= 0) ? fixed : rand_amp(), last_on_final && (b == n - 1));
    endtask

    task automatic do_vblank();
        int seen;
        int pulses;
        seen   = 0;
        pulses = 0;
        hc_out = 10'd0;
        vc_out = 10'(VBL);
        @(posedge clk_25MHz); #1;
        hc_out = 10'd7;
        vc_out = 10'd100;
        if (m_pending) begin
            for (int n = 1; n <= 20 && seen == 0; n++) begin
                @(posedge clk_25MHz); #1;
                if (commit_done === 1'b1)
                    seen = n;
            end
            chk("commit_latency", 32'(seen), 32'd17);
            model_commit();
            check_disp("disp_commit");
            @(posedge clk_25MHz); #1;
            chk("commit_done_width", 32'(commit_done), 32'd0);
            chk("in_ready_after_commit", 32'(bus.in_ready), 32'd1);
        end else begin
            repeat (20) begin
                @(posedge clk_25MHz); #1;
                if (commit_done !== 1'b0)
                    pulses++;
            end
            chk("ignored_vblank_pulses", 32'(pulses), 32'd0);
            check_disp("disp_hold");
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v7;
        int exp6;
        int exp7_old;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_bin   = '0;
        bus.in_last  = 1'b0;
        hc_out       = 10'd5;
        vc_out       = 10'd0;
        model_reset();
        repeat (3) @(posedge clk_25MHz);
        #1;
        chk("rst_commit_done", 32'(commit_done), 32'd0);
        chk("rst_framing_err", 32'(framing_err), 32'd0);
        check_disp("rst_disp");
        rst = 1'b0;
        chk("in_ready_post_rst", 32'(bus.in_ready), 32'd1);

        // Full set of 100 then vblank
        send_beats(NB, 100, 1'b1);
        do_vblank();
        chk("count_after_first", 32'(commit_count), 32'd1);

        // Decay through zero sets: 84 first, reaching 0 after six more
        send_beats(NB, 0, 1'b1);
        do_vblank();
        chk("decay_first", 32'(disp_bins[0]), 32'd84);
        repeat (6) begin
            send_beats(NB, 0, 1'b1);
            do_vblank();
        end
        for (int k = 0; k < NB; k++)
            chk("decay_floor", 32'(disp_bins[k]), 32'd0);

        // Early in_last on beat 5: discarded, vblank ignored, next set from idx 0
        send_beats(6, -1, 1'b1);
        do_vblank();
        send_beats(NB, -1, 1'b1);
        do_vblank();

        // Stall while pending: in_ready low and shadow untouched
        send_beats(NB, -1, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_last  = 1'b1;
        repeat (5) begin
            bus.in_bin = AW'($urandom_range(0, (1 << AW) - 1));
            chk("in_ready_pending", 32'(bus.in_ready), 32'd0);
            @(posedge clk_25MHz); #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        do_vblank();

        // Vblank arriving mid-fill after beat 8
        send_beats(8, -1, 1'b0);
        do_vblank();
        send_beats(NB - 8, -1, 1'b1);
        do_vblank();

        // Full set without in_last is flagged but kept
        send_beats(NB, -1, 1'b0);
        do_vblank();

        for (int it = 0; it < 24; it++) begin
            int kind;
            int j;
            kind = int'($urandom_range(0, 3));
            case (kind)
                0: send_beats(NB, -1, 1'b1);
                1: send_beats(int'($urandom_range(1, NB - 1)), -1, 1'b1);
                2: send_beats(NB, -1, 1'b0);
                default: begin
                    j = int'($urandom_range(1, NB - 1));
                    send_beats(j, -1, 1'b0);
                    do_vblank();
                    send_beats(NB - j, -1, 1'b1);
                end
            endcase
            do_vblank();
        end

        // Reset during COMMIT while bin 7 is due
        v7 = (m_disp[7] > 2000) ? 0 : (1 << AW) - 1;
        send_beats(NB, v7, 1'b1);
        exp6     = commit_value(m_disp[6], v7);
        exp7_old = m_disp[7];
        hc_out = 10'd0;
        vc_out = 10'(VBL);
        @(posedge clk_25MHz); #1;
        hc_out = 10'd7;
        vc_out = 10'd100;
        repeat (8) @(posedge clk_25MHz);
        #1;
        chk("mid_commit_bin6", 32'(disp_bins[6]), 32'(exp6));
        chk("mid_commit_bin7", 32'(disp_bins[7]), 32'(exp7_old));
        rst = 1'b1;
        @(posedge clk_25MHz); #1;
        model_reset();
        check_disp("rst_mid_commit");
        chk("rst_mid_commit_done", 32'(commit_done), 32'd0);
        rst = 1'b0;
        chk("in_ready_after_rst", 32'(bus.in_ready), 32'd1);
        @(posedge clk_25MHz); #1;
        chk("in_ready_after_rst_2", 32'(bus.in_ready), 32'd1);
        chk("no_done_after_rst", 32'(commit_done), 32'd0);
        check_disp("disp_after_rst");

        // Counting restarts from zero after reset
        send_beats(NB, -1, 1'b1);
        do_vblank();
        chk("count_restart", 32'(commit_count), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
